// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the RAM address, captures the
// returned word and hands it to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  halted
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_CAP  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_instr_out;
    logic [DATA_WIDTH-1:0] w_instr_out_nxt;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [ADDR_WIDTH-1:0] w_instr_pc_nxt;
    logic                  r_instr_valid;
    logic                  w_instr_valid_nxt;
    logic                  r_halted;
    logic                  w_halted_nxt;
    logic                  w_is_halt;

    assign address     = r_pc;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

    assign w_is_halt = (r_instr_out[DATA_WIDTH-1 -: 4] == HALT_OPCODE);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr_out   <= w_instr_out_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    // Next-state and next-register logic; a branch overrides the normal flow
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_out_nxt   = r_instr_out;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;

        case (r_state)
            S_REQ: begin
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_instr_out_nxt   = readdata;
                w_instr_pc_nxt    = r_pc;
                w_instr_valid_nxt = 1'b1;
                w_pc_nxt          = r_pc + ADDR_WIDTH'(1);
                w_state_nxt       = S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = w_is_halt ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                w_instr_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        if (branch_taken) begin
            w_pc_nxt          = branch_target;
            w_instr_out_nxt   = r_instr_out;
            w_instr_pc_nxt    = r_instr_pc;
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_REQ;
        end

        w_halted_nxt = (w_state_nxt == S_HALT);
    end

endmodule
